// File: rtl/sub_serial_if.sv
// Handshake and operand/result bundle for the nibble-serial subtractor.
// The master side (consumer/producer) drives operands and handshakes; the slave side is the subtractor.
interface sub_serial_if #(
   parameter int unsigned WIDTH = 32
);
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             start_in;
   logic             ack_in;
   logic             ready_out;
   logic             done_out;
   logic [WIDTH-1:0] diff_out;
   logic             borrow_out;
   logic             zero_out;
   logic             neg_out;
   logic             ovf_out;

   modport master (
      output a_in, b_in, start_in, ack_in,
      input  ready_out, done_out, diff_out, borrow_out, zero_out, neg_out, ovf_out
   );

   modport slave (
      input  a_in, b_in, start_in, ack_in,
      output ready_out, done_out, diff_out, borrow_out, zero_out, neg_out, ovf_out
   );
endinterface

// File: rtl/sub_serial.sv
// Nibble-serial subtractor: computes a - b as a + ~b + 1, four bits per cycle, LSB nibble first.
// Result and flags are held in DONE until acknowledged.
module sub_serial #(
   parameter int unsigned WIDTH = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   sub_serial_if.slave bus
);
   localparam int unsigned NIB = WIDTH / 4;
   localparam int unsigned CW  = $clog2(NIB);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_q, b_q, diff_q;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;
   logic             borrow_q, zero_q, neg_q, ovf_q;
   logic [4:0]       nib_sum;
   logic [WIDTH-1:0] diff_nx;
   logic             last_nib;

   // Operands shift right each cycle, so the active nibble is always [3:0];
   // on the last nibble a_q[3]/b_q[3] are the original sign bits.
   always_comb begin
      nib_sum  = {1'b0, a_q[3:0]} + {1'b0, ~b_q[3:0]} + {4'b0000, carry_q};
      diff_nx  = {nib_sum[3:0], diff_q[WIDTH-1:4]};
      last_nib = (cnt_q == CW'(NIB - 1));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.start_in) state_nx = BUSY;
         BUSY:    if (last_nib)     state_nx = DONE;
         DONE:    if (bus.ack_in)   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         diff_q   <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         borrow_q <= 1'b0;
         zero_q   <= 1'b0;
         neg_q    <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start_in) begin
                  a_q     <= bus.a_in;
                  b_q     <= bus.b_in;
                  carry_q <= 1'b1;
                  cnt_q   <= '0;
               end
            end
            BUSY: begin
               a_q     <= a_q >> 4;
               b_q     <= b_q >> 4;
               carry_q <= nib_sum[4];
               cnt_q   <= cnt_q + 1'b1;
               diff_q  <= diff_nx;
               if (last_nib) begin
                  borrow_q <= ~nib_sum[4];
                  zero_q   <= (diff_nx == '0);
                  neg_q    <= nib_sum[3];
                  ovf_q    <= (a_q[3] ^ b_q[3]) & (nib_sum[3] ^ a_q[3]);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.ready_out  = (state == IDLE);
   assign bus.done_out   = (state == DONE);
   assign bus.diff_out   = diff_q;
   assign bus.borrow_out = borrow_q;
   assign bus.zero_out   = zero_q;
   assign bus.neg_out    = neg_q;
   assign bus.ovf_out    = ovf_q;
endmodule

// File: tb/tb_sub_serial.sv
// Self-checking bench for sub_serial (WIDTH=32) against an arithmetic reference model.
module tb_sub_serial;
   localparam int unsigned W   = 32;
   localparam int unsigned LAT = W / 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   sub_serial_if #(.WIDTH(W)) bus ();
   sub_serial #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   // Reference: result and flags from plain integer arithmetic.
   function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
      longint unsigned ua, ub;
      longint          sd;
      logic [31:0]     d;
      logic            bo, z, n, o;
      ua = longint'(a);
      ub = longint'(b);
      d  = 32'((ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000);
      bo = (ua < ub);
      z  = (d == 32'd0);
      n  = d[31];
      sd = longint'($signed(a)) - longint'($signed(b));
      o  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
      return {d, bo, z, n, o};
   endfunction

   function automatic logic [35:0] observed();
      return {bus.diff_out, bus.borrow_out, bus.zero_out, bus.neg_out, bus.ovf_out};
   endfunction

   task automatic pulse_start(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.a_in = a;
      bus.b_in = b;
      bus.start_in = 1'b1;
      @(posedge clk);
      #1;
      bus.start_in = 1'b0;
      bus.a_in = $urandom;
      bus.b_in = $urandom;
   endtask

   task automatic pulse_ack();
      @(negedge clk);
      bus.ack_in = 1'b1;
      @(posedge clk);
      #1;
      bus.ack_in = 1'b0;
   endtask

   // Counts edges from the current point (1 time unit after an edge) until done_out.
   task automatic wait_done(output int lat);
      lat = 0;
      while (!bus.done_out && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bus.ready_out, bus.done_out, observed()} !== {1'b1, 1'b0, 36'd0}) begin
         failures++;
         $display("FAIL reset: ready/done/outputs=%h required %h", {bus.ready_out, bus.done_out, observed()}, {1'b1, 1'b0, 36'd0});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_vector(input string name, input logic [31:0] a, input logic [31:0] b);
      int lat;
      pulse_start(a, b);
      wait_done(lat);
      checks++;
      if (lat !== LAT) begin
         failures++;
         $display("FAIL %s latency: got %0d required %0d", name, lat, LAT);
      end
      checks++;
      if (observed() !== model(a, b)) begin
         failures++;
         $display("FAIL %s result: got %h required %h", name, observed(), model(a, b));
      end
      pulse_ack();
   endtask

   task automatic test_directed();
      run_vector("a5_b3", 32'd5, 32'd3);
      checks++;
      if (observed() !== {32'h0000_0002, 4'b0000}) begin
         failures++;
         $display("FAIL a5_b3 const: got %h required %h", observed(), {32'h0000_0002, 4'b0000});
      end
      run_vector("a3_b5", 32'd3, 32'd5);
      checks++;
      if (observed() !== {32'hFFFF_FFFE, 4'b1010}) begin
         failures++;
         $display("FAIL a3_b5 const: got %h required %h", observed(), {32'hFFFF_FFFE, 4'b1010});
      end
      run_vector("minneg_1", 32'h8000_0000, 32'd1);
      checks++;
      if (observed() !== {32'h7FFF_FFFF, 4'b0001}) begin
         failures++;
         $display("FAIL minneg_1 const: got %h required %h", observed(), {32'h7FFF_FFFF, 4'b0001});
      end
      run_vector("maxpos_m1", 32'h7FFF_FFFF, 32'hFFFF_FFFF);
      checks++;
      if (observed() !== {32'h8000_0000, 4'b1011}) begin
         failures++;
         $display("FAIL maxpos_m1 const: got %h required %h", observed(), {32'h8000_0000, 4'b1011});
      end
      run_vector("equal", 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      checks++;
      if (observed() !== {32'h0000_0000, 4'b0100}) begin
         failures++;
         $display("FAIL equal const: got %h required %h", observed(), {32'h0000_0000, 4'b0100});
      end
      run_vector("zero_minus_one", 32'd0, 32'd1);
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: b = a;
            1: a = 32'h8000_0000;
            2: b = 32'hFFFF_FFFF;
            3: a = 32'd0;
            default: ;
         endcase
         run_vector("random", a, b);
      end
   endtask

   task automatic test_ignore();
      int          lat;
      logic [35:0] exp;
      exp = model(32'h1234_5678, 32'h0FED_CBA9);
      pulse_start(32'h1234_5678, 32'h0FED_CBA9);
      repeat (2) @(posedge clk);
      #1;
      pulse_start(32'hFFFF_0000, 32'h0000_FFFF);
      pulse_ack();
      wait_done(lat);
      checks++;
      if (lat !== LAT - 4) begin
         failures++;
         $display("FAIL busy_ignore latency: got %0d required %0d", lat, LAT - 4);
      end
      checks++;
      if (observed() !== exp) begin
         failures++;
         $display("FAIL busy_ignore result: got %h required %h", observed(), exp);
      end
      for (int i = 0; i < 5; i++) begin
         pulse_start($urandom, $urandom);
         checks++;
         if ({bus.done_out, bus.ready_out, observed()} !== {1'b1, 1'b0, exp}) begin
            failures++;
            $display("FAIL done_hold cycle %0d: got %h required %h", i, {bus.done_out, bus.ready_out, observed()}, {1'b1, 1'b0, exp});
         end
      end
      pulse_ack();
      checks++;
      if ({bus.ready_out, bus.done_out, observed()} !== {1'b1, 1'b0, exp}) begin
         failures++;
         $display("FAIL after_ack: got %h required %h", {bus.ready_out, bus.done_out, observed()}, {1'b1, 1'b0, exp});
      end
      pulse_ack();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({bus.ready_out, bus.done_out} !== 2'b10) begin
         failures++;
         $display("FAIL idle_ack_ignore: ready/done=%b required 10", {bus.ready_out, bus.done_out});
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      pulse_start(32'd100, 32'd7);
      wait_done(lat);
      @(negedge clk);
      bus.ack_in = 1'b1;
      bus.start_in = 1'b1;
      bus.a_in = 32'd50;
      bus.b_in = 32'd60;
      @(posedge clk);
      #1;
      bus.ack_in = 1'b0;
      checks++;
      if ({bus.ready_out, bus.done_out} !== 2'b10) begin
         failures++;
         $display("FAIL ack_start_same_edge: ready/done=%b required 10", {bus.ready_out, bus.done_out});
      end
      @(posedge clk);
      #1;
      bus.start_in = 1'b0;
      bus.a_in = $urandom;
      checks++;
      if (bus.ready_out !== 1'b0) begin
         failures++;
         $display("FAIL next_edge_accept: ready=%b required 0", bus.ready_out);
      end
      wait_done(lat);
      checks++;
      if ({lat, observed()} !== {LAT, model(32'd50, 32'd60)}) begin
         failures++;
         $display("FAIL back_to_back result: lat=%0d got %h required lat=%0d %h", lat, observed(), LAT, model(32'd50, 32'd60));
      end
      pulse_ack();
   endtask

   task automatic test_reset_busy();
      int seen_done;
      pulse_start(32'hCAFE_F00D, 32'h1357_9BDF);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if ({bus.ready_out, bus.done_out, observed()} !== {1'b1, 1'b0, 36'd0}) begin
         failures++;
         $display("FAIL reset_busy: got %h required %h", {bus.ready_out, bus.done_out, observed()}, {1'b1, 1'b0, 36'd0});
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen_done = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (bus.done_out) seen_done++;
      end
      checks++;
      if (seen_done !== 0) begin
         failures++;
         $display("FAIL reset_abort_no_done: done cycles=%0d required 0", seen_done);
      end
      run_vector("after_reset_10_4", 32'd10, 32'd4);
      checks++;
      if (bus.diff_out !== 32'd6) begin
         failures++;
         $display("FAIL after_reset diff: got %h required 6", bus.diff_out);
      end
   endtask

   initial begin
      bus.a_in = '0;
      bus.b_in = '0;
      bus.start_in = 1'b0;
      bus.ack_in = 1'b0;
      test_reset();
      test_directed();
      test_random();
      test_ignore();
      test_back_to_back();
      test_reset_busy();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sub_serial.md
SUB_SERIAL -- requirements
Module: sub_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits; legal values are multiples of 4, from 8 to 64.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port a_in  input  WIDTH  minuend.
REQ-005 SHALL have port b_in  input  WIDTH  subtrahend.
REQ-006 SHALL have port start_in  input  1  request to start a subtraction.
REQ-007 SHALL have port ack_in  input  1  consumer acknowledges the result.
REQ-008 SHALL have port ready_out  output  1  block is idle and accepts start_in.
REQ-009 SHALL have port done_out  output  1  result and flags are valid.
REQ-010 SHALL have port diff_out  output  WIDTH  a_in - b_in, modulo 2^WIDTH.
REQ-011 SHALL have port borrow_out  output  1  1 when a_in < b_in as unsigned values.
REQ-012 SHALL have port zero_out  output  1  1 when diff_out == 0.
REQ-013 SHALL have port neg_out  output  1  diff_out[WIDTH-1].
REQ-014 SHALL have port ovf_out  output  1  signed overflow of a_in - b_in.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY and DONE; ready_out=1 only in IDLE; done_out=1 only in DONE.
REQ-016 SHALL accept a request on a rising edge where state==IDLE and start_in==1; a_in and b_in are captured on that edge and input changes afterwards are ignored; the FSM then moves to BUSY.
REQ-017 SHALL compute the difference as a + ~b + 1, one 4-bit nibble per cycle, LSB nibble first; the nibble carry is held in a register between cycles and initialised to 1 at acceptance.
REQ-018 SHALL stay in BUSY for exactly WIDTH/4 cycles; done_out SHALL rise WIDTH/4 cycles after the accepting edge (8 cycles for WIDTH=32).
REQ-019 SHALL set borrow_out = NOT(final nibble carry-out).
REQ-020 SHALL set ovf_out = 1 iff a[WIDTH-1] != b[WIDTH-1] and diff[WIDTH-1] != a[WIDTH-1].
REQ-021 SHALL hold diff_out and all flags stable while in DONE, until the edge at which ack_in==1; on that edge the FSM SHALL return to IDLE.
REQ-022 SHALL leave diff_out and the flags at their last values in IDLE; during BUSY, diff_out holds partial results and the flags are undefined (consumers read only when done_out=1).
REQ-023 SHALL ignore start_in in BUSY and DONE, with no capture and no restart.
REQ-024 SHALL ignore ack_in in IDLE and BUSY.
REQ-025 SHALL NOT accept a start on the same edge that acknowledges DONE; the earliest new acceptance is the following edge.
REQ-026 SHALL handle wrap-around of the mod-2^WIDTH result with no saturation.

Reset
REQ-027 SHALL, on any edge with rst_n==0, force state=IDLE, ready_out=1, done_out=0, diff_out=0, borrow_out=0, zero_out=0, neg_out=0 and ovf_out=0.
REQ-028 SHALL give reset priority over start_in and ack_in; reset during BUSY or DONE aborts the operation with no done_out pulse.
REQ-029 SHALL clear the captured operands, nibble counter and carry register on reset.

Verification
REQ-030 SHALL cover (WIDTH=32): a=5, b=3 -> after 8 cycles done_out=1, diff=0x00000002, borrow=0, zero=0, neg=0, ovf=0.
REQ-031 SHALL cover: a=3, b=5 -> diff=0xFFFFFFFE, borrow=1, neg=1, ovf=0, zero=0.
REQ-032 SHALL cover: a=0x80000000, b=1 -> diff=0x7FFFFFFF, ovf=1, borrow=0, neg=0; and a=0x7FFFFFFF, b=0xFFFFFFFF -> diff=0x80000000, ovf=1, borrow=1.
REQ-033 SHALL cover: a=b=0xDEADBEEF -> diff=0, zero=1, borrow=0, ovf=0.
REQ-034 SHALL cover: a start pulse with new operands during BUSY and during DONE -> no effect on the result; ack held off for 5 cycles -> done_out and outputs hold; ack -> ready_out=1 on the next cycle.
REQ-035 SHALL cover: rst_n=0 for 1 cycle at the 4th BUSY cycle -> all outputs 0, ready_out=1, no done_out; a following request a=10, b=4 -> diff=6.
